// File: rtl/rand_fetch_arbiter_if.sv
// ---------------------------------------------------------------------------
// rand_fetch_arbiter_if
// Bundles the requester handshake and the ROM port of rand_fetch_arbiter.
//   req       : per-requester request level, held until its ack
//   seed_load : reseed strobe (only acted on while the arbiter is idle)
//   seed      : new ROM pointer value
//   rom_data  : ROM output, registered inside the ROM (1-cycle latency)
//   rom_addr  : ROM address, straight from the pointer register
//   ack       : one-hot, one-cycle pulse marking rand_data valid
//   rand_data : last fetched random value
//   rand_id   : index of the last granted requester
//   busy      : high while a fetch is in progress
// The master modport is the environment side (requesters plus ROM), the
// slave modport is the arbiter.
// ---------------------------------------------------------------------------
interface rand_fetch_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0] req;
    logic               seed_load;
    logic [7:0]         seed;
    logic [7:0]         rom_data;
    logic [7:0]         rom_addr;
    logic [NUM_REQ-1:0] ack;
    logic [7:0]         rand_data;
    logic [ID_W-1:0]    rand_id;
    logic               busy;

    modport master (
        output req, seed_load, seed, rom_data,
        input  rom_addr, ack, rand_data, rand_id, busy
    );

    modport slave (
        input  req, seed_load, seed, rom_data,
        output rom_addr, ack, rand_data, rand_id, busy
    );
endinterface

// File: rtl/rand_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// rand_fetch_arbiter
// Shares one registered random-number ROM among NUM_REQ cake-spawn
// requesters. A round-robin grant starts a three-cycle IDLE -> FETCH ->
// DELIVER sequence; DELIVER captures the ROM word, pulses the requester's
// ack and steps the ROM pointer through the populated table, skipping
// HOLE_ADDR and wrapping after LAST_ADDR. A seed load in IDLE repositions
// the pointer.
// Ports:
//   clk   : system clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : rand_fetch_arbiter_if.slave (requests, seed, ROM port, results)
// ---------------------------------------------------------------------------
module rand_fetch_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int LAST_ADDR = 144,
    parameter int HOLE_ADDR = 111,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rand_fetch_arbiter_if.slave   bus
);

    localparam logic [7:0] LAST8 = 8'(LAST_ADDR);
    localparam logic [7:0] HOLE8 = 8'(HOLE_ADDR);
    localparam logic [7:0] WRAP8 = 8'(LAST_ADDR + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DELIVER = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_ptr;
    logic [NUM_REQ-1:0]  r_ack;
    logic [7:0]          r_rand_data;
    logic [ID_W-1:0]     r_rand_id;
    logic [ID_W-1:0]     r_last_grant;
    logic                r_busy;

    logic                w_seed_en;
    logic                w_grant_en;
    logic                w_deliver;
    logic                w_grant_vld;
    logic [ID_W-1:0]     w_grant_id;
    int                  w_best;
    int                  w_dist;

    // Successor of a populated address: step over the hole, wrap at the end.
    function automatic logic [7:0] f_next_addr(input logic [7:0] p);
        if (p == LAST8)
            f_next_addr = 8'd0;
        else if (p == HOLE8 - 8'd1)
            f_next_addr = HOLE8 + 8'd1;
        else
            f_next_addr = p + 8'd1;
    endfunction

    // Map any 8-bit seed onto a populated address.
    function automatic logic [7:0] f_fold_seed(input logic [7:0] s);
        logic [7:0] v;
        v = (s > LAST8) ? (s - WRAP8) : s;
        if (v == HOLE8)
            v = HOLE8 + 8'd1;
        f_fold_seed = v;
    endfunction

    // Round-robin pick: the set request closest above last_grant (modulo
    // NUM_REQ) wins, so a requester that was just served goes to the back.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_best      = NUM_REQ;
        w_dist      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ;
            if (bus.req[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_grant_id  = ID_W'(i);
                w_grant_vld = 1'b1;
            end
        end
    end

    // Next-state and per-state control strobes. A seed load in IDLE takes
    // precedence over a pending request, which then waits one cycle.
    always_comb begin
        w_state_next = r_state;
        w_seed_en    = 1'b0;
        w_grant_en   = 1'b0;
        w_deliver    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.seed_load) begin
                    w_seed_en = 1'b1;
                end else if (w_grant_vld) begin
                    w_grant_en   = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // Pointer is stable this cycle; the ROM registers its word.
                w_state_next = S_DELIVER;
            end
            S_DELIVER: begin
                w_deliver    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Registered outputs and arbitration history. Reset abandons any
    // in-flight fetch, so its ack never appears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr        <= 8'd0;
            r_ack        <= '0;
            r_rand_data  <= 8'd0;
            r_rand_id    <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_busy       <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_busy <= (w_state_next != S_IDLE);
            if (w_seed_en)
                r_ptr <= f_fold_seed(bus.seed);
            if (w_grant_en) begin
                r_rand_id    <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
            if (w_deliver) begin
                r_rand_data <= bus.rom_data;
                r_ack       <= ONE_HOT0 << r_rand_id;
                r_ptr       <= f_next_addr(r_ptr);
            end
        end
    end

    assign bus.rom_addr  = r_ptr;
    assign bus.ack       = r_ack;
    assign bus.rand_data = r_rand_data;
    assign bus.rand_id   = r_rand_id;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_rand_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rand_fetch_arbiter
// Drives rand_fetch_arbiter with directed scenarios followed by randomized
// requests, seeds and resets. A transaction-level reference model predicts
// each grant and the ROM word it will return, queueing the expectation; a
// monitor on the falling edge pops and compares whenever an ack is due, and
// tracks the ROM pointer, busy, rand_id and held rand_data every cycle.
// ---------------------------------------------------------------------------
module tb_rand_fetch_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LAST    = 144;
    localparam int HOLE    = 111;
    localparam int ID_W    = $clog2(NUM_REQ);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rand_fetch_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    rand_fetch_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .LAST_ADDR(LAST),
        .HOLE_ADDR(HOLE),
        .ID_W     (ID_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ROM contents: known values at the addresses the scenarios rely on,
    // an arbitrary pattern elsewhere.
    function automatic int rom_f(input int a);
        case (a)
            0:       return 73;
            1:       return 95;
            2:       return 71;
            3:       return 127;
            4:       return 35;
            110:     return 88;
            112:     return 20;
            144:     return 91;
            default: return (a * 7 + 13) % 256;
        endcase
    endfunction

    always @(posedge clk) bus.rom_data <= 8'(rom_f(int'(bus.rom_addr)));

    // Reference model
    function automatic int fold_m(input int s);
        int v;
        v = (s > LAST) ? s - (LAST + 1) : s;
        return (v == HOLE) ? HOLE + 1 : v;
    endfunction

    function automatic int next_m(input int p);
        if (p == LAST) return 0;
        if (p + 1 == HOLE) return HOLE + 1;
        return p + 1;
    endfunction

    typedef struct { int id; int data; } exp_t;
    exp_t q[$];

    int m_phase  = 0;   // 0 idle, 1 fetch, 2 deliver
    int m_ptr    = 0;
    int m_last   = NUM_REQ - 1;
    int m_rid    = 0;
    int m_data   = 0;
    bit m_ack_due = 1'b0;

    always @(posedge clk) begin
        int j;
        bit found;
        cyc++;
        m_ack_due = 1'b0;
        if (!rst_n) begin
            m_phase = 0; m_ptr = 0; m_last = NUM_REQ - 1;
            m_rid = 0; m_data = 0;
            q.delete();
        end else if (m_phase == 0) begin
            if (bus.seed_load) begin
                m_ptr = fold_m(int'(bus.seed));
            end else if (bus.req != 0) begin
                found = 1'b0;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    j = (m_last + k) % NUM_REQ;
                    if (!found && bus.req[j]) begin
                        found  = 1'b1;
                        m_last = j;
                    end
                end
                m_rid = m_last;
                q.push_back('{m_last, rom_f(m_ptr)});
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            m_ack_due = 1'b1;
            m_data    = (q.size() > 0) ? q[0].data : -1;
            m_ptr     = next_m(m_ptr);
            m_phase   = 0;
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("rom_addr", int'(bus.rom_addr), m_ptr);
            chk("addr_legal", int'(bus.rom_addr != 8'(HOLE) && bus.rom_addr <= 8'(LAST)), 1);
            chk("busy", int'(bus.busy), int'(m_phase != 0));
            chk("rand_id", int'(bus.rand_id), m_rid);
            if (m_ack_due) begin
                if (q.size() == 0) begin
                    chk("sb_empty", 0, 1);
                end else begin
                    e = q.pop_front();
                    chk("ack_onehot", int'(bus.ack), 1 << e.id);
                    chk("ack_data", int'(bus.rand_data), e.data);
                end
            end else begin
                chk("ack_idle", int'(bus.ack), 0);
                chk("data_hold", int'(bus.rand_data), m_data);
            end
        end
    end

    // Stimulus helpers
    task automatic wait_any(output int at);
        int n;
        n  = 0;
        at = -1;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ack == 0 && n < 20);
        if (bus.ack != 0) at = cyc;
        else chk("ack_timeout", 0, 1);
    endtask

    task automatic do_fetch(input logic [ID_W-1:0] lane, input int exp_data);
        int at;
        bus.req = NUM_REQ'(1) << lane;
        wait_any(at);
        chk("fetch_id", int'(bus.rand_id), int'(lane));
        chk("fetch_data", int'(bus.rand_data), exp_data);
        bus.req = '0;
    endtask

    task automatic seed_in(input int s);
        bus.seed_load = 1'b1;
        bus.seed      = 8'(s);
        @(negedge clk);
        bus.seed_load = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int at, c0, prev;
        int rr_id[5]   = '{0, 1, 2, 3, 0};
        int rr_data[5] = '{73, 95, 71, 127, 35};
        logic [NUM_REQ-1:0] nr;

        bus.req = '0; bus.seed_load = 1'b0; bus.seed = 8'd0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        chk("rst_rom_addr", int'(bus.rom_addr), 0);
        chk("rst_ack", int'(bus.ack), 0);
        chk("rst_rand_data", int'(bus.rand_data), 0);
        chk("rst_rand_id", int'(bus.rand_id), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rst_n = 1'b1;

        // Basic fetch
        @(negedge clk);
        c0 = cyc;
        bus.req = 4'b0001;
        wait_any(at);
        chk("basic_latency", at - c0, 3);
        chk("basic_ack", int'(bus.ack), 1);
        chk("basic_data", int'(bus.rand_data), 73);
        chk("basic_id", int'(bus.rand_id), 0);
        chk("basic_addr_next", int'(bus.rom_addr), 1);
        bus.req = '0;

        // Round-robin from reset
        apply_reset();
        bus.req = 4'b1111;
        prev = cyc;
        for (int n = 0; n < 5; n++) begin
            wait_any(at);
            chk("rr_id", int'(bus.rand_id), rr_id[n]);
            chk("rr_data", int'(bus.rand_data), rr_data[n]);
            chk("rr_gap", at - prev, 3);
            prev = at;
        end
        bus.req = '0;

        // Hole skip
        @(negedge clk);
        seed_in(110);
        chk("seed110_addr", int'(bus.rom_addr), 110);
        do_fetch(1, 88);
        chk("hole_skip_addr", int'(bus.rom_addr), 112);
        do_fetch(1, 20);

        // Wrap and fold
        seed_in(144);
        do_fetch(2, 91);
        chk("wrap_addr", int'(bus.rom_addr), 0);
        do_fetch(2, 73);
        seed_in(200);
        chk("fold200", int'(bus.rom_addr), 55);
        seed_in(111);
        chk("fold111", int'(bus.rom_addr), 112);
        seed_in(255);
        chk("fold255", int'(bus.rom_addr), 110);

        // seed_load during FETCH is ignored
        bus.req = 4'b0100;
        @(negedge clk);
        chk("fetch_busy", int'(bus.busy), 1);
        seed_in(5);
        @(negedge clk);
        chk("midfetch_ack", int'(bus.ack), 4);
        chk("midfetch_data", int'(bus.rand_data), 88);
        chk("midfetch_addr", int'(bus.rom_addr), 112);
        bus.req = '0;

        // seed_load and req together in IDLE: seed first, grant a cycle later
        @(negedge clk);
        c0 = cyc;
        bus.req = 4'b0001;
        seed_in(3);
        chk("seedreq_busy", int'(bus.busy), 0);
        chk("seedreq_addr", int'(bus.rom_addr), 3);
        wait_any(at);
        chk("seedreq_latency", at - c0, 4);
        chk("seedreq_data", int'(bus.rand_data), 127);
        bus.req = '0;

        // Reset during FETCH abandons the fetch
        @(negedge clk);
        bus.req = 4'b0001;
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_addr", int'(bus.rom_addr), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_data", int'(bus.rand_data), 0);
        chk("midrst_id", int'(bus.rand_id), 0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_ack", int'(bus.ack), 0);
        end
        do_fetch(0, 73);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst_n = 1'b1;
            nr = bus.req;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.ack[i])
                    nr[i] = ($urandom_range(0, 3) == 0);
                else if (!nr[i] && $urandom_range(0, 2) == 0)
                    nr[i] = 1'b1;
                else if (nr[i] && bus.busy && $urandom_range(0, 15) == 0)
                    nr[i] = 1'b0;
            end
            bus.req       = nr;
            bus.seed_load = ($urandom_range(0, 7) == 0);
            bus.seed      = 8'($urandom);
            if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.req = '0;
        bus.seed_load = 1'b0;
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rand_fetch_arbiter.md
# rand_fetch_arbiter

Round-robin arbiter and sequencer that shares the single registered random-number ROM among up to NUM_REQ cake-spawn requesters. It owns the ROM address pointer, walks it through the populated table in order, skips the unpopulated entry, wraps at the end, and allows a reseed. It sits between the per-lane cake spawners and the ROM. Each granted requester receives one 8-bit random value with a one-cycle acknowledge.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- LAST_ADDR, 144, highest populated ROM address; pointer wraps to 0 after it
- HOLE_ADDR, 111, unpopulated ROM address; never presented to the ROM
- ID_W, $clog2(NUM_REQ), width of rand_id

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- req  in  NUM_REQ  per-requester request level; held until its ack
- seed_load  in  1  reseed strobe; honoured only in IDLE
- seed  in  8  new pointer value
- rom_data  in  8  ROM output (registered in ROM, 1-cycle read latency)
- rom_addr  out  8  ROM address; direct register output of the pointer
- ack  out  NUM_REQ  one-hot, one-cycle pulse; rand_data valid for that requester
- rand_data  out  8  fetched random value, held until the next ack
- rand_id  out  ID_W  index of the last granted requester
- busy  out  1  high in FETCH and DELIVER

## Operation
- FSM: IDLE, FETCH, DELIVER.
- IDLE, seed_load=1:
  - Load pointer with fold(seed) and stay in IDLE.
  - No grant is issued that cycle, even if req≠0; requests wait.
- IDLE, seed_load=0, req≠0:
  - Grant the first set req bit, searching upward (modulo NUM_REQ) from last_grant+1.
  - Latch the grant into rand_id and last_grant.
  - Go to FETCH.
- FETCH: one cycle. rom_addr is stable, so the ROM registers rom_data for the pointer. Go to DELIVER.
- DELIVER:
  - rand_data <= rom_data.
  - ack[rand_id] <= 1 for the next cycle only.
  - Pointer <= next(pointer).
  - Go to IDLE.
- next(p): 0 if p==LAST_ADDR; HOLE_ADDR+1 if p==HOLE_ADDR-1; else p+1.
- fold(s):
  - s-(LAST_ADDR+1) if s>LAST_ADDR (8-bit result; 145..255 maps to 0..110).
  - Then, if the value equals HOLE_ADDR, use HOLE_ADDR+1.
- seed_load outside IDLE: ignored and not queued.
- Requester drops req during FETCH/DELIVER: the transaction still completes, the ack is still issued, and the pointer still advances.
- Requester keeps req high after its ack: it re-enters arbitration at lowest priority relative to the others.
- Reset (rst_n=0 at a clock edge), including mid-transaction:
  - state=IDLE, pointer=0, rom_addr=0
  - ack=0, rand_data=0, rand_id=0, busy=0
  - last_grant=NUM_REQ-1, so req[0] has first priority
  - Any in-flight fetch is abandoned and its ack is never issued.

## Timing
- Edge E0: IDLE samples req≠0 → grant; busy high after E0.
- E1: ROM captures data for rom_addr; state → DELIVER.
- E2: rand_data and ack registered; pointer advances; state → IDLE; busy low.
- ack is high for exactly the cycle E2–E3. Request-to-ack latency is 2 edges after the sampling edge.
- The earliest next grant is at E3, because IDLE is occupied during E2–E3. Peak throughput is 1 value per 3 cycles.
- rom_addr changes only at DELIVER edges, seed loads and reset. It never equals HOLE_ADDR and never exceeds LAST_ADDR.
- All outputs are registered; there are no combinational paths from req to ack or rom_addr.

## Test plan
- Basic fetch:
  - Stimulus: reset, then req=0001 held until ack.
  - Required: rom_addr=0; ack=0001 exactly 2 edges after grant; rand_data=73, rand_id=0; rom_addr becomes 1.
- Round-robin:
  - Stimulus: after reset, req=1111 held (each requester re-raises after its ack).
  - Required: grants in order 0,1,2,3,0, 3 cycles apart; rand_data=73,95,71,127,35.
- Hole skip:
  - Stimulus: seed_load with seed=110, then two requests.
  - Required: rand_data=88 (address 110), then 20 (address 112); rom_addr never equals 111.
- Wrap and fold:
  - seed=144, then two requests → 91, then 73 (wrap to 0).
  - seed=200 → rom_addr=55.
  - seed=111 → rom_addr=112.
- Reseed rules:
  - Stimulus: seed_load during FETCH.
  - Required: ignored; the pointer advances normally.
  - Stimulus: seed_load and req together in IDLE.
  - Required: seed loaded first, grant one cycle later.
- Reset mid-operation:
  - Stimulus: rst_n=0 for one edge during FETCH.
  - Required: no ack; all outputs at reset values; the next req=0001 returns 73.
